div_unit: RTL
=============

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider serving the execute stage for MIPS DIV and DIVU.
- The execute stage issues operands with a start/ready handshake and stalls the pipeline while start_in=1 and ready_out=0.
- The 64-bit result is {remainder, quotient}. It flows through the normal EX/MEM/WB path into the hi/lo registers: hi receives the remainder, lo receives the quotient.

Parameters:
- DATA_WIDTH, 32, operand width; result is 2*DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start_in  input  1  divide request; held high by EX until ready_out is seen
- annul_in  input  1  cancel in-flight divide (pipeline flush)
- signed_div_in  input  1  1 = DIV (signed), 0 = DIVU
- opdata1_in  input  DATA_WIDTH  dividend
- opdata2_in  input  DATA_WIDTH  divisor
- result_out  output  2*DATA_WIDTH  {remainder, quotient}
- ready_out  output  1  result valid

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE, result_out=0, ready_out=0, counter=0. Reset has priority over all inputs in every state, including mid-divide.
- States and transitions:
  - IDLE:
    - start_in=1, annul_in=0, divisor!=0 -> ON; operands latched on this edge (edge 0).
    - start_in=1, annul_in=0, divisor==0 -> BYZERO.
    - Otherwise stay in IDLE with ready_out=0 and result_out=0.
  - BYZERO: next edge -> END with result_out=0 and ready_out=1. If annul_in=1 -> IDLE instead.
  - ON: edges 1..DATA_WIDTH each perform one iteration. The dividend shifts into a (DATA_WIDTH+1)-bit partial remainder; subtract the divisor; if non-negative, keep the difference and shift in quotient bit 1, else shift in 0. Counter increments each iteration.
    - On edge DATA_WIDTH+1: sign-correct the result, register result_out, set ready_out=1, go to END.
    - annul_in=1 on any edge in ON -> IDLE; ready_out=0; result_out=0; no result produced.
  - END: hold result_out and ready_out=1 while start_in=1. When start_in=0 on an edge -> IDLE, with ready_out=0 and result_out=0 on that edge. annul_in is ignored in END.
- Latency: ready_out is visible after edge 33 for DATA_WIDTH=32, or after edge 1 for divide-by-zero, counting edge 0 as the edge that accepted start_in.
- Operand changes after edge 0 are ignored. start_in is ignored except in IDLE and END.
- Signed mode:
  - Divide the magnitudes (two's-complement negate negative operands).
  - Negate the quotient if the operand signs differ.
  - Negate the remainder if the dividend is negative.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps), remainder 0.
- Unsigned mode: operands are used as-is; no sign correction.
- Divide-by-zero result is all-zero; no exception is raised.
- Back-to-back: a new start is accepted only from IDLE. At least one cycle with start_in=0 is required between divides.

Test Plan:
- Unsigned: DIVU 100/7, start held -> ready_out rises after edge 33; result_out hi=0x00000002, lo=0x0000000E; after start drops, next edge ready_out=0 and result_out=0.
- Signed: DIV -7/2 (0xFFFFFFF9, 0x00000002) -> hi=0xFFFFFFFF, lo=0xFFFFFFFD. DIV 7/-2 -> hi=0x00000001, lo=0xFFFFFFFD.
- Extremes: DIVU 0xFFFFFFFF/2 -> hi=1, lo=0x7FFFFFFF. DIV 0x80000000/0xFFFFFFFF -> hi=0, lo=0x80000000.
- Divide-by-zero: divisor=0 -> ready_out after edge 1, result_out=0; ON is never entered.
- Annul: assert annul_in at edge 10 of a divide -> IDLE next edge, ready_out never rises. A fresh start then completes correctly (50/5 -> lo=10, hi=0).
- Reset: assert rst at edge 20 mid-divide, and separately in END -> all outputs 0 on the following edge; operand changes after edge 0 leave the result unchanged.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV / DIVU.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   start_in       divide request; held high by EX until ready_out is seen
//   annul_in       cancel an in-flight divide (pipeline flush)
//   signed_div_in  1 = DIV (signed), 0 = DIVU
//   opdata1_in     dividend
//   opdata2_in     divisor
//   result_out     {remainder, quotient}; hi gets remainder, lo gets quotient
//   ready_out      result valid
//   state_dbg      current FSM state (IDLE=0, BYZERO=1, ON=2, END=3)
//
// Handshake: EX raises start_in with operands and keeps it high; the unit
// samples operands only on the accepting edge in IDLE. ready_out stays high
// in END for as long as start_in stays high; the first edge with start_in=0
// returns the unit to IDLE and clears result_out/ready_out on that edge.
module div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_in,
  input  logic                      annul_in,
  input  logic                      signed_div_in,
  input  logic [DATA_WIDTH-1:0]     opdata1_in,
  input  logic [DATA_WIDTH-1:0]     opdata2_in,
  output logic [2*DATA_WIDTH-1:0]   result_out,
  output logic                      ready_out,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ZERO     = '0;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] rem;     // partial remainder (always < divisor)
  logic [DATA_WIDTH-1:0] quo;     // dividend bits shift out, quotient bits shift in
  logic [DATA_WIDTH-1:0] dsr;     // divisor magnitude
  logic                  neg_q;   // operand signs differ (signed mode)
  logic                  neg_r;   // dividend negative (signed mode)
  logic [CNT_WIDTH-1:0]  cnt;

  logic                  op1_neg, op2_neg;
  logic [DATA_WIDTH-1:0] op1_mag, op2_mag;
  logic [DATA_WIDTH:0]   partial, diff;
  logic [DATA_WIDTH-1:0] q_fix, r_fix;
  logic                  accept;

  assign state_dbg = state;

  // Operand magnitudes; 0x80000000 maps to itself, which is the correct
  // unsigned magnitude 2^31.
  assign op1_neg = signed_div_in & opdata1_in[DATA_WIDTH-1];
  assign op2_neg = signed_div_in & opdata2_in[DATA_WIDTH-1];
  assign op1_mag = op1_neg ? (ZERO - opdata1_in) : opdata1_in;
  assign op2_mag = op2_neg ? (ZERO - opdata2_in) : opdata2_in;

  // One restoring step: bring the next dividend bit into the remainder and
  // try to subtract; diff[MSB] set means the trial went negative.
  assign partial = {rem, quo[DATA_WIDTH-1]};
  assign diff    = partial - {1'b0, dsr};

  assign q_fix = neg_q ? (ZERO - quo) : quo;
  assign r_fix = neg_r ? (ZERO - rem) : rem;

  assign accept = start_in & ~annul_in;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = (opdata2_in == ZERO) ? S_BYZERO : S_ON;
      end
      S_BYZERO: state_nxt = annul_in ? S_IDLE : S_END;
      S_ON: begin
        if (annul_in)             state_nxt = S_IDLE;
        else if (cnt == CNT_LAST) state_nxt = S_END;
      end
      S_END: begin
        if (!start_in) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_out <= '0;
      ready_out  <= 1'b0;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dsr        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          result_out <= '0;
          ready_out  <= 1'b0;
          cnt        <= '0;
          if (accept && opdata2_in != ZERO) begin
            rem   <= '0;
            quo   <= op1_mag;
            dsr   <= op2_mag;
            neg_q <= op1_neg ^ op2_neg;
            neg_r <= op1_neg;
          end
        end
        S_BYZERO: begin
          result_out <= '0;
          ready_out  <= ~annul_in;
        end
        S_ON: begin
          if (annul_in) begin
            result_out <= '0;
            ready_out  <= 1'b0;
            cnt        <= '0;
          end else if (cnt == CNT_LAST) begin
            result_out <= {r_fix, q_fix};
            ready_out  <= 1'b1;
          end else begin
            if (!diff[DATA_WIDTH]) begin
              rem <= diff[DATA_WIDTH-1:0];
              quo <= {quo[DATA_WIDTH-2:0], 1'b1};
            end else begin
              rem <= partial[DATA_WIDTH-1:0];
              quo <= {quo[DATA_WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CNT_ONE;
          end
        end
        S_END: begin
          if (!start_in) begin
            result_out <= '0;
            ready_out  <= 1'b0;
          end
        end
        default: begin
          result_out <= '0;
          ready_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule
